data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1001_0000, first byte address served.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-003 The block SHALL have parameter LATENCY, default 2, wait cycles inserted before a legal access completes (0..15).
REQ-004 The block SHALL have ports:
  clk  in  1  clock; all state changes on posedge.
  reset  in  1  synchronous, active-high reset.
  req  in  1  access request from the datapath memory port.
  we  in  1  1 = store, 0 = load.
  addr  in  32  byte address (datapath ALU result).
  size  in  2  00 byte, 01 halfword, 10 word; 11 illegal.
  unsgn  in  1  load zero-extends (lbu/lhu) when 1, sign-extends when 0.
  wdata  in  32  store data; byte/half taken from low bits.
  rdata  out  32  load result, valid while ready=1.
  ready  out  1  one-cycle completion pulse.
  err  out  1  access rejected; valid while ready=1.
  busy  out  1  high whenever a request is in flight.

Function
REQ-005 States SHALL be IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-006 In IDLE with req=1 at a posedge (acceptance edge N), the block SHALL capture we, addr, size, unsgn, wdata into internal registers; later input changes SHALL NOT affect the access.
REQ-007 req SHALL be ignored in WAIT and RESP; no queuing.
REQ-008 At acceptance the block SHALL flag an error if size=11, addr not aligned to size (half: addr[0]!=0; word: addr[1:0]!=0), or (addr - BASE_ADDR) >= DEPTH_WORDS*4 using 32-bit unsigned wrap arithmetic.
REQ-009 Error request: state SHALL go to RESP at edge N; ready=1, err=1, rdata=0 in the following cycle, independent of LATENCY; no memory write.
REQ-010 Legal request, LATENCY=0: state SHALL go to RESP at edge N; otherwise to WAIT with a down-counter loaded with LATENCY-1, decremented each cycle, WAIT->RESP at the edge where counter is 0.
REQ-011 Legal request: ready SHALL be 1 for exactly the single cycle following edge N+LATENCY, err=0.
REQ-012 RESP SHALL always return to IDLE at the next edge; a req present during the RESP cycle SHALL NOT be accepted; earliest next acceptance is the edge after RESP.
REQ-013 Memory SHALL be little-endian: byte at addr[1:0]=k occupies word bits 8k+7:8k; word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-014 Stores SHALL update only the addressed lanes (byte: 1 lane; half: lanes 0-1 or 2-3; word: all), written at the edge entering RESP; rdata=0 during a store response.
REQ-015 Loads SHALL read the word at the edge entering RESP and present the addressed byte/half at rdata[7:0]/[15:0], upper bits sign- or zero-extended per captured unsgn; word loads unmodified.
REQ-016 Outside RESP, ready=0, err=0, rdata holds 0.
REQ-017 Store followed by load to the same address SHALL return the stored data (no stale read).

Reset
REQ-018 reset=1 at a posedge SHALL force IDLE, counter 0, ready=0, err=0, busy=0, rdata=0, overriding req.
REQ-019 Reset in WAIT SHALL abort the access; an aborted store SHALL NOT modify memory; memory contents SHALL NOT be cleared by reset.

Verification
REQ-020 LATENCY=2: store word 0xDEADBEEF to 0x1001_0004 accepted at edge N -> ready=1,err=0 in cycle after edge N+2; busy high cycles N+1..N+3.
REQ-021 Then lb 0x1001_0005 unsgn=0 -> rdata=0xFFFF_FFBE; lbu same -> 0x0000_00BE; lh 0x1001_0006 -> 0xFFFF_DEAD; lw -> 0xDEAD_BEEF.
REQ-022 sb 0x12 to 0x1001_0007 then lw 0x1001_0004 -> 0x12AD_BEEF (other lanes preserved).
REQ-023 lw 0x1001_0002 (misaligned), size=11, and lw 0x1000_FFFC (below base) -> each ready=1, err=1, rdata=0 one cycle after acceptance; memory unchanged.
REQ-024 Store 0x1111_1111 to 0x1001_0000 with reset asserted in WAIT -> no ready pulse, busy=0 after reset edge, subsequent lw returns prior contents.
REQ-025 req held high continuously -> accepted only in IDLE; back-to-back accesses spaced LATENCY+2 cycles apart, one ready pulse each.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: little-endian data memory with fixed wait-state latency and error responses.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        unsgn,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic q_we, q_unsgn;
  logic [1:0] q_size;
  logic [31:0] q_addr, q_wdata;
  logic idle, c_we, c_unsgn;
  logic [1:0] c_size;
  logic [31:0] c_addr, c_wdata, off, wd, word, ld;
  logic [15:0] sh;
  logic [AW-1:0] idx;
  logic bad, go_resp, ok, wr;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  // In IDLE the access being decided is the one on the inputs; afterwards it is the captured one.
  always_comb begin
    idle = state == IDLE;
    c_we = idle ? we : q_we;
    c_unsgn = idle ? unsgn : q_unsgn;
    c_size = idle ? size : q_size;
    c_addr = idle ? addr : q_addr;
    c_wdata = idle ? wdata : q_wdata;
    off = c_addr - BASE_ADDR;
    idx = off[AW+1:2];
    bad = c_size == 2'b11 || (c_size == 2'b01 && c_addr[0]) ||
          (c_size == 2'b10 && c_addr[1:0] != 2'b00) || {1'b0, off} >= LIMIT;
    state_nx = state == RESP ? IDLE :
               state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
               !req ? IDLE : (bad || LATENCY == 0) ? RESP : WAIT;
    go_resp = !reset && state != RESP && state_nx == RESP;
    ok = go_resp && !bad;
    wr = ok && c_we;
    be = c_size == 2'b00 ? 4'b0001 << c_addr[1:0] :
         c_size == 2'b01 ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = c_size == 2'b00 ? {4{c_wdata[7:0]}} :
         c_size == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
    word = mem[idx];
    sh = 16'(word >> {c_addr[1:0], 3'b000});
    ld = c_size == 2'b00 ? {{24{!c_unsgn && sh[7]}}, sh[7:0]} :
         c_size == 2'b01 ? {{16{!c_unsgn && sh[15]}}, sh} : word;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata <= 32'd0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (idle && req) begin
        q_we <= we;
        q_unsgn <= unsgn;
        q_size <= size;
        q_addr <= addr;
        q_wdata <= wdata;
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      rdata <= (ok && !c_we) ? ld : 32'd0;
      err <= go_resp && bad;
    end
  end
  // Memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  assign ready = state == RESP;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks against a byte-array memory model.
module tb_data_mem_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 0, reset = 0, req = 0, we = 0, unsgn = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [1:0] size = 0;
  logic ready, err, busy;
  int total = 0, bad = 0;
  logic [7:0] m [DEPTH*4];

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
    .unsgn(unsgn), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] o;
    o = a - BASE;
    if (s == 2'b11) return 1;
    if (a % (32'd1 << s) != 0) return 1;
    return o >= DEPTH * 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [11:0] o;
    logic [7:0] b;
    logic [15:0] h;
    o = 12'(a - BASE);
    b = m[o];
    h = {m[o+1], b};
    if (s == 0) return u ? 32'(b) : 32'($signed(b));
    if (s == 1) return u ? 32'(h) : 32'($signed(h));
    return {m[o+3], m[o+2], h};
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [11:0] o;
    o = 12'(a - BASE);
    for (int i = 0; i < (1 << s); i++) m[o + 12'(i)] = d[8*i +: 8];
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                        input logic [31:0] d, output logic [31:0] got);
    logic e;
    logic [31:0] exp;
    int k;
    e = model_err(a, s);
    exp = (!e && !w) ? model_load(a, s, u) : 32'd0;
    @(negedge clk);
    req = 1; we = w; addr = a; size = s; unsgn = u; wdata = d;
    @(posedge clk); #1;
    if (!e && w) model_store(a, s, d);
    k = 0;
    while (!ready && k < 20) begin
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_wait a=%h k=%0d got=%b want=1", a, k, busy); end
      req = 1'($urandom); we = 1'($urandom); addr = $urandom; size = 2'($urandom);
      unsgn = 1'($urandom); wdata = $urandom;
      @(posedge clk); #1;
      k++;
    end
    got = rdata;
    total++;
    if (ready !== 1'b1 || k != (e ? 0 : LAT)) begin
      bad++; $display("FAIL latency a=%h s=%0d got=%0d ready=%b want=%0d", a, s, k, ready, e ? 0 : LAT);
    end
    total++;
    if (err !== e) begin bad++; $display("FAIL err a=%h s=%0d got=%b want=%b", a, s, err, e); end
    total++;
    if (rdata !== exp) begin bad++; $display("FAIL rdata a=%h s=%0d u=%b got=%h want=%h", a, s, u, rdata, exp); end
    @(posedge clk); #1;
    req = 0;
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
      bad++; $display("FAIL after_resp a=%h got busy=%b ready=%b err=%b rdata=%h want 0", a, busy, ready, err, rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1; req = 1; we = 1; addr = BASE; size = 2; wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 0 || ready !== 0 || err !== 0 || rdata !== 0) begin
      bad++; $display("FAIL reset_state got busy=%b ready=%b err=%b rdata=%h want 0", busy, ready, err, rdata);
    end
    reset = 0; req = 0;
  endtask

  task automatic test_init();
    logic [31:0] g;
    for (int i = 0; i < 64; i++) access(1, BASE + 32'(4 * i), 2, 0, $urandom, g);
  endtask

  task automatic test_directed();
    logic [31:0] g;
    access(1, 32'h1001_0004, 2, 0, 32'hDEAD_BEEF, g);
    access(0, 32'h1001_0005, 0, 0, 0, g);
    total++; if (g !== 32'hFFFF_FFBE) begin bad++; $display("FAIL lb got=%h want=FFFFFFBE", g); end
    access(0, 32'h1001_0005, 0, 1, 0, g);
    total++; if (g !== 32'h0000_00BE) begin bad++; $display("FAIL lbu got=%h want=000000BE", g); end
    access(0, 32'h1001_0006, 1, 0, 0, g);
    total++; if (g !== 32'hFFFF_DEAD) begin bad++; $display("FAIL lh got=%h want=FFFFDEAD", g); end
    access(0, 32'h1001_0004, 2, 0, 0, g);
    total++; if (g !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw got=%h want=DEADBEEF", g); end
    access(1, 32'h1001_0007, 0, 0, 32'h5555_5512, g);
    access(0, 32'h1001_0004, 2, 0, 0, g);
    total++; if (g !== 32'h12AD_BEEF) begin bad++; $display("FAIL sb_merge got=%h want=12ADBEEF", g); end
    access(1, 32'h1001_0002, 2, 0, 32'h0, g);
    access(1, 32'h1001_0004, 3, 0, 32'h0, g);
    access(1, 32'h1000_FFFC, 2, 0, 32'h0, g);
    access(0, 32'h1001_0002, 2, 0, 0, g);
    access(0, 32'h1001_0004, 2, 0, 0, g);
    total++; if (g !== 32'h12AD_BEEF) begin bad++; $display("FAIL err_no_write got=%h want=12ADBEEF", g); end
  endtask

  task automatic test_abort();
    logic [31:0] g;
    access(1, BASE, 2, 0, 32'hA5A5_5A5A, g);
    @(negedge clk);
    req = 1; we = 1; addr = BASE; size = 2; unsgn = 0; wdata = 32'h1111_1111;
    @(posedge clk); #1;
    req = 0;
    total++; if (busy !== 1) begin bad++; $display("FAIL abort_busy got=%b want=1", busy); end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    reset = 0;
    total++; if (busy !== 0 || ready !== 0) begin bad++; $display("FAIL abort_reset got busy=%b ready=%b want 0", busy, ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (ready !== 0) begin bad++; $display("FAIL abort_ready cyc=%0d got=%b want=0", i, ready); end
    end
    access(0, BASE, 2, 0, 0, g);
    total++; if (g !== 32'hA5A5_5A5A) begin bad++; $display("FAIL abort_mem got=%h want=A5A55A5A", g); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic er;
    exp = model_load(BASE + 32'd8, 2, 0);
    @(negedge clk);
    req = 1; we = 0; addr = BASE + 32'd8; size = 2; unsgn = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      er = (c >= LAT) && ((c - LAT) % (LAT + 2) == 0);
      total++;
      if (ready !== er || (er && rdata !== exp)) begin
        bad++; $display("FAIL b2b cyc=%0d got ready=%b rdata=%h want ready=%b rdata=%h", c, ready, rdata, er, exp);
      end
    end
    req = 0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    total++; if (busy !== 0) begin bad++; $display("FAIL b2b_drain got busy=%b want=0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] a, g;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 255));
      access(1'($urandom), a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, g);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
